iterative_shifter: RTL and testbench
====================================

# iterative_shifter

Multi-cycle, parametrised shift unit for the datapath. It generalises the fixed left-shift-by-two used for branch offsets into a variable-amount shifter with four modes: logical left, logical right, arithmetic right and rotate left. It shifts at most STEP bits per clock, which keeps the shifter narrow and off the critical path. It sits beside the ALU and is driven by the controller through a Start/Busy/Done handshake.

## Interface
- WIDTH, 32: operand and result width, ≥ 2.
- STEP, 4: maximum bits shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.
- AMT_W, $clog2(WIDTH): width of Amount; derived, not overridden.
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only when Busy = 0.
- Mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTL; sampled with Start.
- Amount  input  AMT_W  shift distance 0..WIDTH-1; sampled with Start.
- InputVal  input  WIDTH  operand; sampled with Start.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse; OutputVal valid from this cycle.
- OutputVal  output  WIDTH  result; held until the next Done.

## Operation
- States: IDLE, SHIFT.
- IDLE, Start = 1 at an edge:
  - Capture InputVal into the work register, Amount into the remaining count rem, and Mode.
  - Busy goes to 1 and the state moves to SHIFT.
- SHIFT, at each edge:
  - Compute s = min(rem, STEP).
  - Apply one step of s bits in the captured mode; rem -= s.
  - If the new rem is 0, load the stepped result into OutputVal, pulse Done, clear Busy and return to IDLE.
- Amount = 0: one SHIFT cycle with s = 0; OutputVal = InputVal.
- Mode semantics per step:
  - SLL: zero fill at the LSB.
  - SRL: zero fill at the MSB.
  - SRA: fill with the captured sign bit (bit WIDTH-1 of the work register).
  - ROTL: bits leaving the MSB re-enter at the LSB.
- Composing steps gives exactly the single-shot result of shifting by Amount.
- Start while Busy = 1 is ignored; operands are not re-sampled and no error is flagged.
- Input changes after capture do not affect the operation in flight.
- Reset (any time, including mid-SHIFT): state IDLE, rem 0, work register 0.
  - Busy 0, Done 0, OutputVal 0, all immediately.
  - The aborted operation never produces Done.

## Timing
- Reset values: Busy 0, Done 0, OutputVal 0.
- Latency: Start sampled at edge k; Done is high for the cycle after edge k + L, where L = max(1, ceil(Amount/STEP)).
- Worst case L = ceil((WIDTH-1)/STEP), i.e. 8 cycles at the defaults.
- Busy is high from edge k to edge k + L. It is low in the Done cycle.
- Back-to-back: Start high during the Done cycle is accepted at the next edge, giving no dead cycle between operations.
- Done lasts exactly one cycle. OutputVal changes only at a Done edge or on reset.
- No combinational path from any input to any output.

## Structure
- Shared package (shift_pkg):
  - Mode encodings SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROTL.
  - State encodings IDLE, SHIFT.
- Sub-module shift_step:
  - Purely combinational, parametrised by WIDTH and STEP.
  - Inputs: data, mode, s (0..STEP). Output: the single-step result.
  - Instantiated once.
- Top level holds the FSM, the rem counter, the work register, OutputVal and the Done/Busy registers.

## Test plan
Defaults: WIDTH 32, STEP 4.
- SLL, 0x0000_0001, Amount 2 → Done one cycle after capture (L = 1), OutputVal 0x0000_0004; matches the legacy branch-offset shift.
- SRA 0x8000_0000, Amount 31 → L = 8, OutputVal 0xFFFF_FFFF. Repeat as SRL → 0x0000_0001.
- ROTL 0x8000_0001, Amount 4 → L = 1, 0x0000_0018. ROTL 0x1234_5678, Amount 8 → L = 2, 0x3456_7812.
- SLL 0xDEAD_BEEF, Amount 0 → L = 1, OutputVal 0xDEAD_BEEF.
- Handshake:
  - Start SRL 0xF000_0000 by 16; Start again while Busy with different operands → ignored, result 0x0000_F000 after L = 4.
  - Start held during the Done cycle → second operation captured next edge, no gap.
- Reset asserted mid-SHIFT (cycle 3 of an Amount-31 operation) → Busy, Done and OutputVal 0 immediately; no Done after release. A fresh Start then completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared mode and state encodings for the iterative shifter
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_ROTL = 2'b11
  } shift_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one combinational shift step of 0..STEP bits
import shift_pkg::*;

module shift_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int SW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  input  shift_mode_t      i_mode,
  input  logic [SW-1:0]    i_s,
  output logic [WIDTH-1:0] o_data
);

  // Select the single-step result; s = 0 passes the data through in every mode.
  always_comb begin
    int w_back;
    o_data = i_data;
    w_back = WIDTH - int'(i_s);
    case (i_mode)
      SHIFT_SLL:  o_data = i_data << i_s;
      SHIFT_SRL:  o_data = i_data >> i_s;
      SHIFT_SRA:  o_data = $signed(i_data) >>> i_s;
      SHIFT_ROTL: o_data = (i_data << i_s) | (i_data >> w_back);
      default:    o_data = i_data;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// rtl/iterative_shifter.sv - multi-cycle variable shifter, STEP bits per clock
import shift_pkg::*;

module iterative_shifter #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [AMT_W-1:0] i_amount,
  input  logic [WIDTH-1:0] i_input_val,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_output_val
);

  localparam int SW = $clog2(STEP + 1);

  shift_state_t     r_state;
  shift_state_t     w_state_next;
  shift_mode_t      r_mode;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_out;

  logic [SW-1:0]    w_s;
  logic [AMT_W-1:0] w_rem_next;
  logic [WIDTH-1:0] w_step;
  logic             w_capture;
  logic             w_finish;

  // Step size for this cycle: the remaining count, capped at STEP.
  always_comb begin
    w_s = SW'(STEP);
    if (int'(r_rem) < STEP) begin
      w_s = SW'(r_rem);
    end
    w_rem_next = r_rem - AMT_W'(w_s);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_data (r_work),
    .i_mode (r_mode),
    .i_s    (w_s),
    .o_data (w_step)
  );

  // FSM next state: accept Start in IDLE, finish when the count reaches zero.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_capture    = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (w_rem_next == '0) begin
          w_finish     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: capture operands, step the work register, publish the result.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mode <= SHIFT_SLL;
      r_work <= '0;
      r_rem  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_out  <= '0;
    end else begin
      r_done <= w_finish;
      if (w_capture) begin
        r_mode <= shift_mode_t'(i_mode);
        r_work <= i_input_val;
        r_rem  <= i_amount;
        r_busy <= 1'b1;
      end else if (r_state == SHIFT) begin
        r_work <= w_step;
        r_rem  <= w_rem_next;
        if (w_finish) begin
          r_out  <= w_step;
          r_busy <= 1'b0;
        end
      end
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_output_val = r_out;

endmodule

// File: tb/tb_iterative_shifter.sv
// tb/tb_iterative_shifter.sv - scoreboard bench for iterative_shifter
module tb_iterative_shifter;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [1:0]  i_mode = 2'b00;
  logic [4:0]  i_amount = 5'd0;
  logic [31:0] i_input_val = 32'd0;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_output_val;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] exp;
    int          lat;
    time         t_cap;
  } item_t;

  item_t       sb_q[$];
  logic [31:0] last_out = 32'd0;

  iterative_shifter #(.WIDTH(32), .STEP(4)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_mode       (i_mode),
    .i_amount     (i_amount),
    .i_input_val  (i_input_val),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_output_val (o_output_val)
  );

  always #5 i_clk = ~i_clk;

  // Single-shot reference of the four shift modes.
  function automatic logic [31:0] ref_shift(input logic [1:0] m, input int a, input logic [31:0] v);
    logic [31:0] r;
    case (m)
      2'b00: r = v << a;
      2'b01: r = v >> a;
      2'b10: begin
        r = v >> a;
        if (v[31]) r = r | ~(32'hFFFF_FFFF >> a);
      end
      default: r = (a == 0) ? v : ((v << a) | (v >> (32 - a)));
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input int a);
    return (a == 0) ? 1 : (a + 3) / 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Wait for idle, present an operation, and record its expectation at the capture edge.
  task automatic issue(input logic [1:0] m, input int a, input logic [31:0] v,
                       input logic [31:0] exp, input int lat);
    int n = 0;
    item_t it;
    @(negedge i_clk);
    while (o_busy && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    i_start = 1'b1;
    i_mode = m;
    i_amount = 5'(a);
    i_input_val = v;
    @(posedge i_clk);
    it.exp = exp;
    it.lat = lat;
    it.t_cap = $time;
    sb_q.push_back(it);
    #1;
    i_start = 1'b0;
    i_mode = 2'($urandom);
    i_amount = 5'($urandom);
    i_input_val = $urandom;
  endtask

  task automatic issue_rand();
    logic [1:0]  m = 2'($urandom);
    int          a = int'($urandom_range(0, 31));
    logic [31:0] v = $urandom;
    issue(m, a, v, ref_shift(m, a, v), ref_lat(a));
  endtask

  // Monitor: pop on Done and compare result, latency and handshake state.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_done) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=done required=no_done");
        end else begin
          item_t it;
          it = sb_q.pop_front();
          check("result", o_output_val, it.exp);
          check("latency", 32'(int'(($time - it.t_cap - 5) / 10)), 32'(it.lat));
          check("busy_in_done", {31'd0, o_busy}, 32'd0);
          last_out = it.exp;
        end
      end else begin
        check("output_held", o_output_val, last_out);
        if (sb_q.size() > 0 && $time > sb_q[0].t_cap) begin
          check("busy_in_flight", {31'd0, o_busy}, 32'd1);
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_done", {31'd0, o_done}, 32'd0);
    check("reset_out", o_output_val, 32'd0);
    i_reset = 1'b0;

    issue(2'b00, 2,  32'h0000_0001, 32'h0000_0004, 1);
    issue(2'b10, 31, 32'h8000_0000, 32'hFFFF_FFFF, 8);
    issue(2'b01, 31, 32'h8000_0000, 32'h0000_0001, 8);
    issue(2'b11, 4,  32'h8000_0001, 32'h0000_0018, 1);
    issue(2'b11, 8,  32'h1234_5678, 32'h3456_7812, 2);
    issue(2'b00, 0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);

    issue(2'b01, 16, 32'hF000_0000, 32'h0000_F000, 4);
    @(negedge i_clk);
    i_start = 1'b1;
    i_mode = 2'b00;
    i_amount = 5'd1;
    i_input_val = 32'h1111_1111;
    @(negedge i_clk);
    i_start = 1'b0;

    for (int i = 0; i < 60; i++) begin
      issue_rand();
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(negedge i_clk);
    end

    issue(2'b10, 31, 32'h8000_0000, 32'hFFFF_FFFF, 8);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    sb_q.delete();
    last_out = 32'd0;
    #1;
    check("abort_busy", {31'd0, o_busy}, 32'd0);
    check("abort_done", {31'd0, o_done}, 32'd0);
    check("abort_out", o_output_val, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (12) @(negedge i_clk);

    issue(2'b11, 8, 32'h1234_5678, 32'h3456_7812, 2);
    for (int i = 0; i < 10; i++) issue_rand();

    n = 0;
    while (sb_q.size() > 0 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", sb_q.size());
    end
    repeat (3) @(negedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
